// File: rtl/rmii_rx_deframer.sv
// -----------------------------------------------------------------------------
// rmii_rx_deframer
//
// Receive-side RMII front end. Samples crs_dv/rxd from the PHY and strips the
// preamble and SFD. It then forwards the frame payload one dibit at a time,
// with a one-cycle strobe per dibit, and ends each frame with a done pulse.
// The dibit order is the wire order, LSB first. The end-of-frame crs_dv toggling
// that RMII allows is tolerated. Frames that are not a whole number of bytes,
// are empty, or are too long are flagged with err alongside done.
//
// Parameters
//   MIN_PREAMBLE_DIBITS  minimum run of 01 dibits required before the SFD
//   MAX_DIBITS           payload dibits forwarded per frame; excess is dropped
//
// Ports
//   clk      in   50 MHz RMII reference clock
//   reset_n  in   asynchronous active-low reset
//   crs_dv   in   RMII carrier sense / data valid
//   rxd      in   [1:0] RMII receive dibit
//   out      out  [1:0] payload dibit, valid while outclk is high
//   outclk   out  one-cycle strobe per payload dibit
//   done     out  one-cycle end-of-frame pulse
//   err      out  one-cycle malformed-frame pulse, only together with done
//   active   out  high while a frame is in preamble or data
// -----------------------------------------------------------------------------
module rmii_rx_deframer #(
  parameter int MIN_PREAMBLE_DIBITS = 8,
  parameter int MAX_DIBITS          = 6088
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       crs_dv,
  input  logic [1:0] rxd,
  output logic [1:0] out,
  output logic       outclk,
  output logic       done,
  output logic       err,
  output logic       active
);

  localparam int DW = $clog2(MAX_DIBITS + 1);
  localparam int PW = $clog2(MIN_PREAMBLE_DIBITS + 1);
  localparam logic [DW-1:0] MAX_D = DW'(MAX_DIBITS);
  localparam logic [PW-1:0] MIN_P = PW'(MIN_PREAMBLE_DIBITS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREAMBLE,
    S_DATA,
    S_END
  } state_t;

  // One pin sample: carrier flag plus the dibit seen with it.
  typedef struct packed {
    logic       crs;
    logic [1:0] dibit;
  } sample_t;

  state_t        state;
  sample_t       r;        // newest sample, used as one-cycle lookahead
  sample_t       h;        // sample being acted on this cycle
  logic [DW-1:0] dcnt;
  logic [PW-1:0] pre_cnt;
  logic          ovf;

  // NOTE: every register here, the output registers included, takes
  // non-blocking assignments. Each decision then reads the values from before
  // the clock edge, and the r -> h shift behaves as a true two-stage pipeline.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      r       <= '0;
      h       <= '0;
      dcnt    <= '0;
      pre_cnt <= '0;
      ovf     <= 1'b0;
      out     <= 2'b00;
      outclk  <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      active  <= 1'b0;
    end else begin
      // The pins keep flowing through the pipeline in every state, END included.
      // Nothing sampled while a frame is closing is lost.
      r      <= '{crs: crs_dv, dibit: rxd};
      h      <= r;
      outclk <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;

      case (state)
        S_IDLE: begin
          // Leading 00 dibits at carrier rise are skipped. A preamble only
          // starts at the first 01.
          if (h.crs && h.dibit == 2'b01) begin
            state   <= S_PREAMBLE;
            pre_cnt <= PW'(1);
            active  <= 1'b1;
          end
        end

        S_PREAMBLE: begin
          if (!h.crs) begin
            state  <= S_IDLE;
            active <= 1'b0;
          end else begin
            case (h.dibit)
              2'b01: begin
                if (pre_cnt != MIN_P) pre_cnt <= pre_cnt + PW'(1);
              end
              2'b11: begin
                if (pre_cnt >= MIN_P) begin
                  // The SFD itself is consumed and never forwarded.
                  state <= S_DATA;
                  dcnt  <= '0;
                end else begin
                  state  <= S_IDLE;
                  active <= 1'b0;
                end
              end
              default: begin
                // False carrier: drop it without reporting a frame.
                state  <= S_IDLE;
                active <= 1'b0;
              end
            endcase
          end
        end

        S_DATA: begin
          if (!h.crs && !r.crs) begin
            // Two low samples in a row end the frame. A single low sample
            // followed by a high one is the PHY's end-of-frame toggling, so the
            // dibit carried with it is still data.
            state  <= S_END;
            done   <= 1'b1;
            err    <= (dcnt[1:0] != 2'b00) || ovf || (dcnt == '0);
            active <= 1'b0;
          end else if (dcnt < MAX_D) begin
            out    <= h.dibit;
            outclk <= 1'b1;
            dcnt   <= dcnt + DW'(1);
          end else begin
            // The counter stops at the limit. Further dibits are only noted.
            ovf <= 1'b1;
          end
        end

        S_END: begin
          ovf   <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rmii_rx_deframer.sv
module tb_rmii_rx_deframer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       crs_dv = 1'b0;
  logic [1:0] rxd = 2'b00;

  logic [1:0] out, s_out;
  logic       outclk, done, err, active;
  logic       s_outclk, s_done, s_err, s_active;

  always #10 clk = ~clk;

  rmii_rx_deframer dut (
    .clk(clk), .reset_n(reset_n), .crs_dv(crs_dv), .rxd(rxd),
    .out(out), .outclk(outclk), .done(done), .err(err), .active(active)
  );

  // Second instance with a tiny payload limit, used for the oversize case.
  rmii_rx_deframer #(.MAX_DIBITS(8)) dut_small (
    .clk(clk), .reset_n(reset_n), .crs_dv(crs_dv), .rxd(rxd),
    .out(s_out), .outclk(s_outclk), .done(s_done), .err(s_err), .active(s_active)
  );

  int checks = 0;
  int passes = 0;

  // Monitor: samples the outputs 1 ns after every rising edge.
  int         cyc = 0;
  logic [1:0] dq[$];
  logic [1:0] s_dq[$];
  int oc_cnt, s_oc_cnt, done_cnt, err_cnt, s_done_cnt, s_err_cnt;
  int first_oc_cyc, last_oc_cyc, done_cyc, overlap_cnt, act_at_done, act_rise_cyc;
  logic prev_act;

  task automatic clear_mon();
    dq.delete(); s_dq.delete();
    oc_cnt = 0; s_oc_cnt = 0; done_cnt = 0; err_cnt = 0;
    s_done_cnt = 0; s_err_cnt = 0; overlap_cnt = 0; act_at_done = 0;
    first_oc_cyc = -1; last_oc_cyc = -1; done_cyc = -1; act_rise_cyc = -1;
  endtask

  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (outclk) begin
      dq.push_back(out);
      oc_cnt = oc_cnt + 1;
      if (first_oc_cyc < 0) first_oc_cyc = cyc;
      last_oc_cyc = cyc;
    end
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
      if (err) err_cnt = err_cnt + 1;
      if (outclk) overlap_cnt = overlap_cnt + 1;
      if (active) act_at_done = act_at_done + 1;
    end
    if (active && !prev_act && act_rise_cyc < 0) act_rise_cyc = cyc;
    prev_act = active;
    if (s_outclk) begin
      s_dq.push_back(s_out);
      s_oc_cnt = s_oc_cnt + 1;
    end
    if (s_done) begin
      s_done_cnt = s_done_cnt + 1;
      if (s_err) s_err_cnt = s_err_cnt + 1;
    end
  end

  // Stimulus: inputs change on the falling edge and are sampled on the next rising edge.
  int drv_edge;
  int pre_e0, pay_e0;

  task automatic drive(input logic c, input logic [1:0] d);
    @(negedge clk);
    crs_dv = c;
    rxd = d;
    drv_edge = cyc + 1;
  endtask

  task automatic send_frame(input int npre, input logic [1:0] sfd, input int ndib,
                            input logic [31:0] bits, input bit toggle);
    logic c;
    for (int i = 0; i < npre; i++) begin
      drive(1'b1, 2'b01);
      if (i == 0) pre_e0 = drv_edge;
    end
    drive(1'b1, sfd);
    for (int i = 0; i < ndib; i++) begin
      c = 1'b1;
      if (toggle && i >= ndib - 4) c = ((i - (ndib - 4)) % 2) == 1;
      drive(c, 2'(bits >> (2 * i)));
      if (i == 0) pay_e0 = drv_edge;
    end
    repeat (6) drive(1'b0, 2'b00);
  endtask

  // Expected normal payload: bytes 0xA5, 0x3C split LSB first.
  logic [1:0] exp_norm[8] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b00, 2'b11, 2'b11, 2'b00};

  task automatic check_normal(input string tag);
    checks++;
    if (oc_cnt !== 8) $display("FAIL %s outclk_count got %0d want 8", tag, oc_cnt);
    else passes++;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i >= dq.size()) $display("FAIL %s dibit%0d missing want %b", tag, i, exp_norm[i]);
      else if (dq[i] !== exp_norm[i]) $display("FAIL %s dibit%0d got %b want %b", tag, i, dq[i], exp_norm[i]);
      else passes++;
    end
    checks++;
    if (done_cnt !== 1) $display("FAIL %s done_count got %0d want 1", tag, done_cnt);
    else passes++;
    checks++;
    if (err_cnt !== 0) $display("FAIL %s err_count got %0d want 0", tag, err_cnt);
    else passes++;
    checks++;
    if (done_cyc !== last_oc_cyc + 1) $display("FAIL %s done_timing got cyc %0d want %0d", tag, done_cyc, last_oc_cyc + 1);
    else passes++;
    checks++;
    if (overlap_cnt !== 0) $display("FAIL %s done_with_outclk got %0d want 0", tag, overlap_cnt);
    else passes++;
    checks++;
    if (act_at_done !== 0) $display("FAIL %s active_at_done got %0d want 0", tag, act_at_done);
    else passes++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({out, outclk, done, err, active} !== 6'b0)
      $display("FAIL reset_outputs got %b want 000000", {out, outclk, done, err, active});
    else passes++;
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({outclk, done, active} !== 3'b0) $display("FAIL reset_idle got %b want 000", {outclk, done, active});
    else passes++;
  endtask

  task automatic test_normal_frame();
    clear_mon();
    send_frame(31, 2'b11, 8, 32'h3CA5, 1'b0);
    check_normal("normal");
    checks++;
    if (first_oc_cyc !== pay_e0 + 2) $display("FAIL latency got cyc %0d want %0d", first_oc_cyc, pay_e0 + 2);
    else passes++;
    checks++;
    if (act_rise_cyc !== pre_e0 + 2) $display("FAIL active_rise got cyc %0d want %0d", act_rise_cyc, pre_e0 + 2);
    else passes++;
  endtask

  task automatic test_eof_toggle();
    clear_mon();
    send_frame(31, 2'b11, 8, 32'h3CA5, 1'b1);
    check_normal("toggle");
  endtask

  task automatic test_short_preamble();
    clear_mon();
    send_frame(5, 2'b11, 0, 32'h0, 1'b0);
    checks++;
    if (oc_cnt !== 0 || done_cnt !== 0) $display("FAIL short_pre outclk/done got %0d/%0d want 0/0", oc_cnt, done_cnt);
    else passes++;
    checks++;
    if (active !== 1'b0) $display("FAIL short_pre active got %b want 0", active);
    else passes++;
    clear_mon();
    send_frame(2, 2'b10, 0, 32'h0, 1'b0);
    checks++;
    if (oc_cnt !== 0 || done_cnt !== 0) $display("FAIL false_carrier outclk/done got %0d/%0d want 0/0", oc_cnt, done_cnt);
    else passes++;
    checks++;
    if (active !== 1'b0) $display("FAIL false_carrier active got %b want 0", active);
    else passes++;
  endtask

  task automatic test_malformed_length();
    clear_mon();
    send_frame(31, 2'b11, 6, 32'h0A5, 1'b0);
    checks++;
    if (oc_cnt !== 6) $display("FAIL malformed outclk_count got %0d want 6", oc_cnt);
    else passes++;
    checks++;
    if (done_cnt !== 1 || err_cnt !== 1) $display("FAIL malformed done/err got %0d/%0d want 1/1", done_cnt, err_cnt);
    else passes++;
  endtask

  task automatic test_oversize();
    clear_mon();
    send_frame(31, 2'b11, 12, 32'h00F3CA5, 1'b0);
    checks++;
    if (s_oc_cnt !== 8) $display("FAIL oversize outclk_count got %0d want 8", s_oc_cnt);
    else passes++;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i >= s_dq.size()) $display("FAIL oversize dibit%0d missing want %b", i, exp_norm[i]);
      else if (s_dq[i] !== exp_norm[i]) $display("FAIL oversize dibit%0d got %b want %b", i, s_dq[i], exp_norm[i]);
      else passes++;
    end
    checks++;
    if (s_done_cnt !== 1 || s_err_cnt !== 1) $display("FAIL oversize done/err got %0d/%0d want 1/1", s_done_cnt, s_err_cnt);
    else passes++;
  endtask

  task automatic test_reset_mid_frame();
    clear_mon();
    for (int i = 0; i < 31; i++) drive(1'b1, 2'b01);
    drive(1'b1, 2'b11);
    drive(1'b1, 2'b01);
    drive(1'b1, 2'b01);
    drive(1'b1, 2'b10);
    @(negedge clk);
    checks++;
    if (outclk !== 1'b1 || active !== 1'b1) $display("FAIL mid_frame_busy outclk/active got %b/%b want 1/1", outclk, active);
    else passes++;
    reset_n = 1'b0;
    crs_dv = 1'b0;
    rxd = 2'b00;
    #1;
    checks++;
    if ({out, outclk, done, err, active} !== 6'b0)
      $display("FAIL async_reset outputs got %b want 000000", {out, outclk, done, err, active});
    else passes++;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (done_cnt !== 0) $display("FAIL aborted_done got %0d want 0", done_cnt);
    else passes++;
    clear_mon();
    send_frame(31, 2'b11, 8, 32'h3CA5, 1'b0);
    check_normal("after_reset");
  endtask

  initial begin
    clear_mon();
    prev_act = 1'b0;
    test_reset();
    test_normal_frame();
    test_eof_toggle();
    test_short_preamble();
    test_malformed_length();
    test_oversize();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/rmii_rx_deframer.md
# rmii_rx_deframer

Receive-side RMII front end: samples `crs_dv`/`rxd` from the PHY, strips preamble and SFD, and emits the frame payload as a dibit stream with a per-dibit strobe plus end-of-frame `done`. It handles RMII end-of-frame `crs_dv` toggling and flags malformed frames. It sits between the RMII pins and the dibit-to-byte converter; `out`, `outclk` and `done` connect directly to that converter's dibit input, strobe and `done_in`.

## Interface
- `MIN_PREAMBLE_DIBITS`, default 8: minimum count of consecutive `01` dibits required before the SFD dibit.
- `MAX_DIBITS`, default 6088 (1522 bytes × 4): payload dibits forwarded per frame. Any excess is dropped and flagged.
- `clk`  in  1  50 MHz RMII reference clock. This is the block's one clock.
- `reset_n`  in  1  Reset, asynchronous and active-low.
- `crs_dv`  in  1  RMII carrier sense / data valid.
- `rxd`  in  2  RMII receive dibit, LSB first on the wire.
- `out`  out  2  Payload dibit, valid while `outclk` is high.
- `outclk`  out  1  One-cycle strobe, once per payload dibit.
- `done`  out  1  One-cycle pulse at end of frame.
- `err`  out  1  One-cycle pulse, only ever coincident with `done`: frame malformed.
- `active`  out  1  High in the PREAMBLE and DATA states.

## Operation
- Pipeline registers:
  - `r` (crs, dibit) captures the pins every cycle.
  - `h` captures `r` every cycle.
  - All state decisions use `h` (current) and `r` (lookahead).
- **IDLE**
  - Go to PREAMBLE with `pre_cnt` = 1 when `h.crs` = 1 and `h.dibit` = 01.
  - Otherwise stay in IDLE. This covers leading `00` dibits at carrier rise.
- **PREAMBLE**
  - `h.crs` = 0: go to IDLE silently.
  - `h.dibit` = 01: increment `pre_cnt`, saturating at `MIN_PREAMBLE_DIBITS`.
  - `h.dibit` = 11 with `pre_cnt` ≥ `MIN_PREAMBLE_DIBITS`: go to DATA, clear `dcnt`. The SFD dibit is not emitted.
  - `h.dibit` = 11 with `pre_cnt` short: go to IDLE silently.
  - `h.dibit` = 00 or 10 (false carrier): go to IDLE silently. No `done`, no `err`.
- **DATA**
  - `h.dibit` is valid if `h.crs` = 1, or if `h.crs` = 0 and `r.crs` = 1 (end-of-frame toggling).
  - For a valid dibit with `dcnt` < `MAX_DIBITS`:
    - set `out` ← `h.dibit` and `outclk` ← 1;
    - increment `dcnt`.
  - For a valid dibit with `dcnt` = `MAX_DIBITS`:
    - do not emit it (`outclk` stays 0);
    - set the `ovf` flag.
  - When `h.crs` = 0 and `r.crs` = 0, the frame has ended. Go to END and discard `h`.
- **END** (one cycle)
  - Pulse `done` = 1.
  - Set `err` = 1 if `dcnt[1:0]` ≠ 0 (not a whole number of bytes), if `ovf` = 1, or if `dcnt` = 0.
  - Clear `ovf` and go to IDLE.
  - A new frame may start being recognised on the next cycle. Pins sampled during END still enter `r`/`h` normally and are never lost.
- Width rules:
  - `dcnt` has width clog2(`MAX_DIBITS`+1) and never wraps.
  - `pre_cnt` has width clog2(`MIN_PREAMBLE_DIBITS`+1) and saturates.

## Timing
- Reset values: `out` = 00, `outclk` = 0, `done` = 0, `err` = 0, `active` = 0; state = IDLE; `r`, `h`, `dcnt`, `pre_cnt` and `ovf` all cleared.
- Asserting `reset_n` mid-frame clears all outputs immediately (asynchronously), emits no `done`, and the block then waits in IDLE.
- Latency: a dibit sampled at edge E0 appears on `out` with `outclk` high after edge E2.
- `outclk` rate is at most one strobe per cycle. Dibits arriving on back-to-back cycles give back-to-back strobes.
- `done` is high on the cycle after the last `outclk`. It is never coincident with `outclk`.
- `done` never fires for frames rejected in PREAMBLE.
- `active` rises the cycle after the first preamble `01` reaches `h`. It falls in the same cycle that `done` is high.
- All outputs are registered. There is no combinational path from the pins to any output.

## Test plan
- Normal frame:
  - Stimulus: 31 × `01`, then `11`, then bytes 0xA5, 0x3C, then `crs_dv` low.
  - Required response: exactly 8 `outclk` pulses carrying 01,01,10,10,00,11,11,00, then `done` = 1 with `err` = 0.
- End-of-frame toggling:
  - Stimulus: the same frame, with `crs_dv` pattern 0,1,0,1 over the last four data dibits (data held valid).
  - Required response: all 8 dibits emitted; `done` only after two consecutive low samples.
- Short preamble and false carrier:
  - Stimulus: 5 × `01` then `11`; separately, `01`,`01`,`10`.
  - Required response: no `outclk`, no `done`, `active` returns to 0.
- Malformed length:
  - Stimulus: 6 data dibits.
  - Required response: 6 `outclk` pulses, then `done` = 1 with `err` = 1.
- Oversize:
  - Stimulus: `MAX_DIBITS` = 8, 12-dibit payload.
  - Required response: 8 `outclk` pulses, then `done` = 1 with `err` = 1.
- Reset mid-frame:
  - Stimulus: `reset_n` low after 3 data dibits, then released, then a normal frame.
  - Required response: outputs 0 at once and no `done` for the aborted frame; the following frame is received exactly as in the normal-frame case.
